// File: rtl/md_pkg.sv
// Shared types and constants for the md_sequencer multiply/divide unit.
// Contents: FSM state enum, op encodings, step counts, magnitude helper.
package md_pkg;

   localparam int unsigned MD_WIDTH     = 32;
   localparam int unsigned MD_CNT_W     = 5;
   localparam int unsigned MD_MUL_STEPS = 16;
   localparam int unsigned MD_DIV_STEPS = 32;

   localparam logic MD_OP_MUL = 1'b0;
   localparam logic MD_OP_DIV = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MUL,
      ST_DIV,
      ST_FIX,
      ST_DONE
   } md_state_t;

   // Two's-complement magnitude; -2^31 maps to 0x80000000 read as unsigned.
   function automatic logic [MD_WIDTH-1:0] md_abs(input logic [MD_WIDTH-1:0] x);
      return x[MD_WIDTH-1] ? MD_WIDTH'(-x) : x;
   endfunction

endpackage

// File: rtl/booth_r4_step.sv
// One radix-4 Booth iteration: decode the low multiplier triple, add the
// selected partial product at the top of the accumulator, shift right by 2.
// Ports:
//   i_acc   [63:0] current accumulator (signed)
//   i_mplr  [33:0] shifted multiplier with appended 0 LSB
//   i_mcand [63:0] sign-extended multiplicand
//   o_acc   [63:0] next accumulator
//   o_mplr  [33:0] next shifted multiplier
module booth_r4_step (
   input  logic [63:0] i_acc,
   input  logic [33:0] i_mplr,
   input  logic [63:0] i_mcand,
   output logic [63:0] o_acc,
   output logic [33:0] o_mplr
);

   logic [63:0] w_m2;
   logic [63:0] w_pp;
   logic [65:0] w_sum;

   assign w_m2 = i_mcand + i_mcand;

   // Booth digit select: 0, +-M, +-2M.
   always_comb begin
      w_pp = '0;
      case (i_mplr[2:0])
         3'b001, 3'b010: w_pp = i_mcand;
         3'b011:         w_pp = w_m2;
         3'b100:         w_pp = 64'(-w_m2);
         3'b101, 3'b110: w_pp = 64'(-i_mcand);
         default:        w_pp = '0;
      endcase
   end

   // Two guard bits absorb the +-2M add at weight 2^32; after the shift the
   // value always fits back in 64 bits, and no low bits are lost.
   assign w_sum  = {{2{i_acc[63]}}, i_acc} + ({{2{w_pp[63]}}, w_pp} << 32);
   assign o_acc  = w_sum[65:2];
   assign o_mplr = {{2{i_mplr[33]}}, i_mplr[33:2]};

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle signed multiply/divide unit owning the HI/LO result registers.
// MUL: 16 radix-4 Booth steps. DIV: 32 non-restoring steps plus one fix-up.
// Build option: define MD_DIV_EN to compile the divide path; without it a
// DIV request completes in one cycle with zero results.
// Ports:
//   clk, reset_n       clock, async active-low reset
//   start, op, a, b    request (op 0 = MUL, 1 = DIV), sampled in IDLE/DONE
//   busy               operation in progress
//   done               one-cycle pulse, hi/lo newly valid
//   hi, lo             MUL: product high/low; DIV: remainder/quotient
//   div_by_zero        DIV with b == 0, held until next accepted start
module md_sequencer
   import md_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);

   md_state_t             r_state;
   md_state_t             w_state_nxt;
   logic                  w_accept;

   logic [MD_CNT_W-1:0]   r_cnt;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_dbz;
   logic [31:0]           r_hi;
   logic [31:0]           r_lo;

   logic [63:0]           r_acc;
   logic [33:0]           r_mplr;
   logic [31:0]           r_mcand;
   logic [63:0]           w_acc_nxt;
   logic [33:0]           w_mplr_nxt;

   booth_r4_step u_booth (
      .i_acc   (r_acc),
      .i_mplr  (r_mplr),
      .i_mcand ({{32{r_mcand[31]}}, r_mcand}),
      .o_acc   (w_acc_nxt),
      .o_mplr  (w_mplr_nxt)
   );

`ifdef MD_DIV_EN
   logic [32:0]           r_rem;
   logic [31:0]           r_quo;
   logic [31:0]           r_dvs;
   logic                  r_neg_q;
   logic                  r_neg_r;
   logic [32:0]           w_rem_sh;
   logic [32:0]           w_rem_nxt;
   logic [31:0]           w_quo_nxt;
   logic [32:0]           w_rem_fix;
   logic [31:0]           w_rem_res;
   logic [31:0]           w_quo_res;

   // Non-restoring step: subtract if remainder non-negative, else add back.
   assign w_rem_sh  = {r_rem[31:0], r_quo[31]};
   assign w_rem_nxt = r_rem[32] ? (w_rem_sh + {1'b0, r_dvs})
                                : (w_rem_sh - {1'b0, r_dvs});
   assign w_quo_nxt = {r_quo[30:0], ~w_rem_nxt[32]};

   // Fix-up: restore a negative remainder, then apply operand signs.
   assign w_rem_fix = r_rem[32] ? (r_rem + {1'b0, r_dvs}) : r_rem;
   assign w_rem_res = r_neg_r ? 32'(-w_rem_fix[31:0]) : w_rem_fix[31:0];
   assign w_quo_res = r_neg_q ? 32'(-r_quo) : r_quo;
`endif

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               w_accept = 1'b1;
               if (op == MD_OP_MUL) begin
                  w_state_nxt = ST_MUL;
               end else begin
`ifdef MD_DIV_EN
                  w_state_nxt = (b == '0) ? ST_DONE : ST_DIV;
`else
                  w_state_nxt = ST_DONE;
`endif
               end
            end else if (r_state == ST_DONE) begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_MUL: if (r_cnt == MD_CNT_W'(MD_MUL_STEPS - 1)) w_state_nxt = ST_DONE;
`ifdef MD_DIV_EN
         ST_DIV: if (r_cnt == MD_CNT_W'(MD_DIV_STEPS - 1)) w_state_nxt = ST_FIX;
         ST_FIX: w_state_nxt = ST_DONE;
`endif
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_dbz   <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_acc   <= '0;
         r_mplr  <= '0;
         r_mcand <= '0;
`ifdef MD_DIV_EN
         r_rem   <= '0;
         r_quo   <= '0;
         r_dvs   <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
`endif
      end else begin
         r_busy <= (w_state_nxt == ST_MUL) || (w_state_nxt == ST_DIV) ||
                   (w_state_nxt == ST_FIX);
         r_done <= (w_state_nxt == ST_DONE);
         if (w_accept) begin
            r_cnt   <= '0;
            r_dbz   <= 1'b0;
            r_acc   <= '0;
            r_mplr  <= {b[31], b, 1'b0};
            r_mcand <= a;
`ifdef MD_DIV_EN
            r_rem   <= '0;
            r_quo   <= md_abs(a);
            r_dvs   <= md_abs(b);
            r_neg_q <= a[31] ^ b[31];
            r_neg_r <= a[31];
            if (op == MD_OP_DIV && b == '0) begin
               r_hi  <= a;
               r_lo  <= '1;
               r_dbz <= 1'b1;
            end
`else
            if (op == MD_OP_DIV) begin
               r_hi <= '0;
               r_lo <= '0;
            end
`endif
         end else begin
            case (r_state)
               ST_MUL: begin
                  r_acc  <= w_acc_nxt;
                  r_mplr <= w_mplr_nxt;
                  r_cnt  <= r_cnt + MD_CNT_W'(1);
                  if (w_state_nxt == ST_DONE) begin
                     r_hi <= w_acc_nxt[63:32];
                     r_lo <= w_acc_nxt[31:0];
                  end
               end
`ifdef MD_DIV_EN
               ST_DIV: begin
                  r_rem <= w_rem_nxt;
                  r_quo <= w_quo_nxt;
                  r_cnt <= r_cnt + MD_CNT_W'(1);
               end
               ST_FIX: begin
                  r_hi <= w_rem_res;
                  r_lo <= w_quo_res;
               end
`endif
               default: ;
            endcase
         end
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign hi          = r_hi;
   assign lo          = r_lo;
   assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer: stimulus pushes reference results,
// a negedge monitor pops and compares on every done pulse.
module tb_md_sequencer;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic        op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        div_by_zero;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
      int          lat;   // edges from the start edge to the done cycle; also busy cycles
      int          st;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   bcnt   = 0;

   md_sequencer #(.WIDTH(32)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .op          (op),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .hi          (hi),
      .lo          (lo),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Reference: plain signed arithmetic.
   function automatic exp_t model(input bit o, input logic [31:0] aa, input logic [31:0] bb);
      exp_t   e;
      longint p;
      int     sa, sb;
      e.st = 0;
      if (o == 1'b0) begin
         p     = longint'($signed(aa)) * longint'($signed(bb));
         e.hi  = p[63:32];
         e.lo  = p[31:0];
         e.dbz = 1'b0;
         e.lat = 16;
      end else begin
`ifdef MD_DIV_EN
         sa = $signed(aa);
         sb = $signed(bb);
         if (bb == 32'd0) begin
            e.hi = aa; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1; e.lat = 0;
         end else begin
            if (aa == 32'h8000_0000 && bb == 32'hFFFF_FFFF) begin
               e.lo = 32'h8000_0000; e.hi = 32'd0;
            end else begin
               e.lo = sa / sb; e.hi = sa % sb;
            end
            e.dbz = 1'b0; e.lat = 33;
         end
`else
         sa = 0; sb = 0;
         e.hi = 32'd0; e.lo = 32'd0; e.dbz = 1'b0; e.lat = 0;
`endif
      end
      return e;
   endfunction

   // Monitor: compare each done pulse against the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (reset_n) begin
         if (busy) bcnt++;
         if (done) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_done actual=1 required=0 cyc=%0d", cyc);
            end else begin
               e = q.pop_front();
               chk("hi", hi, e.hi);
               chk("lo", lo, e.lo);
               chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
               chk("latency", 32'(cyc - e.st), 32'(e.lat));
               chk("busy_cycles", 32'(bcnt), 32'(e.lat));
            end
            bcnt = 0;
         end
      end
   end

   // Issue one op at the first IDLE/DONE cycle; start is left asserted.
   task automatic go(input bit o, input logic [31:0] aa, input logic [31:0] bb);
      exp_t e;
      int   n;
      n = 0;
      @(negedge clk);
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         checks++;
         errors++;
         $display("FAIL busy_timeout actual=1 required=0");
      end
      start = 1'b1; op = o; a = aa; b = bb;
      @(posedge clk);
      #1;
      e    = model(o, aa, bb);
      e.st = cyc;
      q.push_back(e);
   endtask

   task automatic idle(input int n);
      start = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [31:0] rnd_opnd();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'h8000_0000;
         2:       return 32'h7FFF_FFFF;
         3:       return 32'hFFFF_FFFF;
         4, 5:    return 32'($urandom_range(0, 20)) - 32'd10;
         default: return 32'($urandom);
      endcase
   endfunction

   initial begin
      int n;
      reset_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk("rst_dbz", 32'(div_by_zero), 32'd0);
      reset_n = 1'b1;
      idle(2);

      // Directed cases.
      go(1'b0, 32'd7, 32'hFFFF_FFFD);         idle(1);
      go(1'b0, 32'h8000_0000, 32'h8000_0000); idle(1);
      go(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF); idle(1);
      go(1'b1, 32'hFFFF_FFF9, 32'd2);         idle(1);
      go(1'b1, 32'h8000_0000, 32'hFFFF_FFFF); idle(1);
      go(1'b1, 32'd5, 32'd0);                 idle(2);

      // Start pulsed mid-MUL must be ignored; then back-to-back ops.
      go(1'b0, 32'd3, 32'd4);
      start = 1'b0;
      repeat (4) @(negedge clk);
      start = 1'b1; op = 1'b1; a = 32'd9; b = 32'd0;
      @(posedge clk);
      #1 start = 1'b0;
      go(1'b0, 32'h0001_1111, 32'hFFFF_2222);
      go(1'b1, 32'd100, 32'd7);
      go(1'b1, 32'd1, 32'd0);
      go(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      idle(1);

      // Reset mid-MUL: outputs clear, no done, then a clean MUL.
      go(1'b0, 32'd1234, 32'd5678);
      start = 1'b0;
      repeat (8) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_hi", hi, 32'd0);
      chk("abort_lo", lo, 32'd0);
      chk("abort_dbz", 32'(div_by_zero), 32'd0);
      q.delete();
      bcnt = 0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      idle(20);
      go(1'b0, 32'd2, 32'd2);
      idle(1);

      // Randomized mix.
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 3));
         go(1'($urandom_range(0, 1)), rnd_opnd(), rnd_opnd());
      end

      // Drain.
      start = 1'b0;
      n = 0;
      while (q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout actual=%0d required=0", q.size());
      end
      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
